pixel_to_char_grid: RTL
=======================

// Module: pixel_to_char_grid
// PURPOSE
//  Parametrised text-grid mapper between the VGA timing generator and the char/font ROM lookup.
//  Maps the streamed pixel coordinate to character cell index and intra-cell pixel offset.
//  Uses incremental counters, with no divide or multiply, so any cell size works.
//  Adds a configurable window origin, hardware vertical scroll over a circular text buffer, and a blinking cursor flag.
// PARAMETERS
//  CHAR_W       8    cell width in pixels (2..16, any value)
//  CHAR_H       16   cell height in pixels (2..32, any value)
//  COLS         80   text columns
//  ROWS         25   text rows
//  X_START      0    first window pixel column
//  Y_START      32   first window pixel row
//  BLINK_FRAMES 30   frames per cursor blink half-period
// PORTS
//  clk          in   1     pixel clock, one pixel per cycle
//  rst_n        in   1     async active-low reset
//  pix_x        in   10    screen pixel x, increments by 1 per clk across a line
//  pix_y        in   10    screen pixel y, constant across a line
//  scroll_row   in   5     text row displayed at top of window
//  cursor_en    in   1     cursor display enable
//  cursor_index in   11    cursor cell index
//  en           out  1     output cell fields valid (pixel inside window)
//  char_index   out  11    physical cell index 0..ROWS*COLS-1
//  char_pixel_x out  4     pixel x in cell 0..CHAR_W-1
//  char_pixel_y out  5     pixel y in cell 0..CHAR_H-1
//  cursor_hit   out  1     pixel lies in the visible cursor cell
// BEHAVIOUR
//  - Reset: all outputs 0, all counters 0, synced=0, blink phase=visible.
//  - Latency: fixed 2 clk. Outputs at cycle n+2 describe the pix_x/pix_y presented at cycle n.
//  - Window: X_START <= x < X_START+COLS*CHAR_W and Y_START <= y < Y_START+ROWS*CHAR_H.
//    Outside the window: en=0 and char_index, char_pixel_x, char_pixel_y, cursor_hit all 0.
//  - Frame start is (x==X_START, y==Y_START). At frame start:
//    - latch scroll_row (a value >= ROWS latches 0),
//    - set cy=0 and row_base=latched_scroll*COLS,
//    - set synced=1,
//    - advance the blink counter.
//  - Line start is x==X_START with y inside the window and y > Y_START.
//    - cy increments; at cy==CHAR_H-1 it wraps to 0 and row_base += COLS.
//    - row_base wraps modulo ROWS*COLS: if row_base+COLS >= ROWS*COLS then row_base = row_base+COLS-ROWS*COLS.
//  - Within a line: cx, col reset to 0 at x==X_START; cx increments per clk.
//    At cx==CHAR_W-1, cx wraps to 0 and col increments.
//  - char_index = row_base+col, computed as a registered add only.
//    It never reaches ROWS*COLS, including on the last column of the wrapped row.
//  - Stable register values are read once per frame: scroll_row changes mid-frame take effect at the next frame start.
//  - Blink: a frame counter 0..BLINK_FRAMES-1 toggles blink phase on wrap.
//    cursor_hit = en & cursor_en & phase_visible & (char_index==cursor_index).
//  - cursor_index >= ROWS*COLS: cursor_hit never asserts.
//  - Reset asserted mid-frame: outputs drop to 0 asynchronously.
//    After release, en stays 0 until the next frame start (synced gate). Partial frames are never mapped.
//  - Simultaneous frame start and line start: the frame-start action wins.
// STRUCTURE
//  - Shared include vga_text_defs.vh: CHAR_W, CHAR_H, COLS, ROWS, and the widths IDX_W=11, PIX_W=10.
//  - Window constants and TEXT_CELLS = ROWS*COLS also live there for reuse by the char RAM.
//  - Sub-module frame_blink_counter holds the frame-count and blink-phase logic.
//    Ports: clk, rst_n, frame_tick, phase_visible. Parameter: BLINK_FRAMES.
//  - Top level: stage 1 holds window compare and cx/col/cy/row_base counters; stage 2 holds output registers and cursor compare.
// TESTING
//  - Reset, then x=32,y=40: en stays 0 until the frame start (0,32) is seen. Then x=0,y=32 -> 2 clk later en=1, char_index=0, px=0, py=0.
//  - scroll_row=0, pixel (639,431): char_index=1999, char_pixel_x=7, char_pixel_y=15. Pixel (0,432): en=0 and all fields 0.
//  - scroll_row=24, pixel (0,32): char_index=1920. Pixel (0,48): char_index=0 (wrap). scroll_row=30 latches as 0.
//  - Change scroll_row 0->5 at y=200: the current frame is unchanged; next frame, pixel (0,32) gives char_index=400.
//  - cursor_en=1, cursor_index=81, BLINK_FRAMES=2: cursor_hit is high on x=8..15, y=48..63 in frames 0-1, low in frames 2-3. It stays 0 if cursor_index=2000.
//  - CHAR_W=6, CHAR_H=12, COLS=10, ROWS=4, X_START=20, Y_START=8, pixel (33,21): char_index=12, px=1, py=1.
//    Random pixel sweep is checked against a divide-based reference model.

Source files
------------

// File: rtl/pixel_to_char_grid_pkg.sv
// Shared widths, default text-grid geometry and arithmetic helpers for the
// pixel-to-character mapper and the char RAM that sits next to it.
package pixel_to_char_grid_pkg;

  localparam int IDX_W = 11;
  localparam int PIX_W = 10;
  localparam int CX_W  = 4;
  localparam int CY_W  = 5;
  localparam int SCR_W = 5;
  localparam int SUM_W = IDX_W + 1;

  localparam int DEF_CHAR_W     = 8;
  localparam int DEF_CHAR_H     = 16;
  localparam int DEF_COLS       = 80;
  localparam int DEF_ROWS       = 25;
  localparam int DEF_X_START    = 0;
  localparam int DEF_Y_START    = 32;
  localparam int DEF_TEXT_CELLS = DEF_ROWS * DEF_COLS;

  typedef struct packed {
    logic             win;
    logic [CX_W-1:0]  cx;
    logic [CY_W-1:0]  cy;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row_base;
  } stage1_t;

  // row * cols as a shift-and-add over the row bits; cols is a constant
  function automatic logic [IDX_W-1:0] row_offset(input logic [SCR_W-1:0] row, input int cols);
    logic [IDX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SCR_W; i++) begin
      if (row[i]) acc = acc + IDX_W'(cols << i);
      else        acc = acc;
    end
    return acc;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int step,
                                                input int cells);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, base} + SUM_W'(step);
    if (sum >= SUM_W'(cells)) sum = sum - SUM_W'(cells);
    else                      sum = sum;
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_to_char_grid_if.sv
// Pixel-coordinate input and character-cell output bundle between the VGA
// timing generator (master) and the grid mapper (slave).
interface pixel_to_char_grid_if;
  import pixel_to_char_grid_pkg::*;

  logic [PIX_W-1:0] pix_x;
  logic [PIX_W-1:0] pix_y;
  logic [SCR_W-1:0] scroll_row;
  logic             cursor_en;
  logic [IDX_W-1:0] cursor_index;
  logic             en;
  logic [IDX_W-1:0] char_index;
  logic [CX_W-1:0]  char_pixel_x;
  logic [CY_W-1:0]  char_pixel_y;
  logic             cursor_hit;

  modport master (
    output pix_x, pix_y, scroll_row, cursor_en, cursor_index,
    input  en, char_index, char_pixel_x, char_pixel_y, cursor_hit
  );

  modport slave (
    input  pix_x, pix_y, scroll_row, cursor_en, cursor_index,
    output en, char_index, char_pixel_x, char_pixel_y, cursor_hit
  );

endinterface

// File: rtl/pixel_to_char_grid_frame_blink_counter.sv
// Counts frames and flips the cursor blink phase every BLINK_FRAMES ticks.
module frame_blink_counter #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic phase_visible
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             vis_s;

  // next frame count and blink phase
  always_comb begin
    cnt_s = cnt_r;
    vis_s = phase_visible;
    if (frame_tick) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = '0;
        vis_s = ~phase_visible;
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // counter and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      phase_visible <= 1'b1;
    end else begin
      cnt_r         <= cnt_s;
      phase_visible <= vis_s;
    end
  end

endmodule

// File: rtl/pixel_to_char_grid.sv
// Maps the streamed pixel coordinate to a character cell index and intra-cell
// offset with incremental counters; two-stage pipeline, scroll and cursor blink.
module pixel_to_char_grid
  import pixel_to_char_grid_pkg::*;
#(
  parameter int CHAR_W       = DEF_CHAR_W,
  parameter int CHAR_H       = DEF_CHAR_H,
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int X_START      = DEF_X_START,
  parameter int Y_START      = DEF_Y_START,
  parameter int BLINK_FRAMES = 30
) (
  input logic                 clk,
  input logic                 rst_n,
  pixel_to_char_grid_if.slave bus
);

  localparam int TEXT_CELLS = ROWS * COLS;
  localparam logic [PIX_W:0]   X_LO     = (PIX_W + 1)'(X_START);
  localparam logic [PIX_W:0]   X_HI     = (PIX_W + 1)'(X_START + COLS * CHAR_W);
  localparam logic [PIX_W:0]   Y_LO     = (PIX_W + 1)'(Y_START);
  localparam logic [PIX_W:0]   Y_HI     = (PIX_W + 1)'(Y_START + ROWS * CHAR_H);
  localparam logic [CX_W-1:0]  CX_LAST  = CX_W'(CHAR_W - 1);
  localparam logic [CY_W-1:0]  CY_LAST  = CY_W'(CHAR_H - 1);
  localparam logic [SCR_W:0]   ROWS_L   = (SCR_W + 1)'(ROWS);

  logic [PIX_W:0]   x_s;
  logic [PIX_W:0]   y_s;
  logic             x_in_s;
  logic             y_in_s;
  logic             frame_start_s;
  logic             line_start_s;
  logic             frame_tick_s;
  logic             phase_visible_s;
  logic [IDX_W-1:0] scroll_base_s;
  logic [IDX_W-1:0] idx_s;
  logic             synced_r;
  stage1_t          s1_r;
  stage1_t          s1_s;

  assign x_s           = {1'b0, bus.pix_x};
  assign y_s           = {1'b0, bus.pix_y};
  assign x_in_s        = (x_s >= X_LO) && (x_s < X_HI);
  assign y_in_s        = (y_s >= Y_LO) && (y_s < Y_HI);
  assign frame_start_s = (x_s == X_LO) && (y_s == Y_LO);
  assign line_start_s  = (x_s == X_LO) && y_in_s && (y_s > Y_LO);
  // blink counts completed frames, so the first sync after reset only starts frame 0
  assign frame_tick_s  = frame_start_s & synced_r;
  assign idx_s         = s1_r.row_base + s1_r.col;

  // first displayed row offset; out-of-range scroll values show row 0
  always_comb begin
    if ({1'b0, bus.scroll_row} < ROWS_L) scroll_base_s = row_offset(bus.scroll_row, COLS);
    else                                 scroll_base_s = '0;
  end

  // stage 1: window compare and cell counters for the current pixel
  always_comb begin
    s1_s     = s1_r;
    s1_s.win = x_in_s & y_in_s & (synced_r | frame_start_s);
    if (x_s == X_LO) begin
      s1_s.cx  = '0;
      s1_s.col = '0;
    end else if (s1_r.cx == CX_LAST) begin
      s1_s.cx  = '0;
      s1_s.col = s1_r.col + IDX_W'(1);
    end else begin
      s1_s.cx  = s1_r.cx + CX_W'(1);
    end
    if (frame_start_s) begin
      s1_s.cy       = '0;
      s1_s.row_base = scroll_base_s;
    end else if (line_start_s) begin
      if (s1_r.cy == CY_LAST) begin
        s1_s.cy       = '0;
        s1_s.row_base = wrap_add(s1_r.row_base, COLS, TEXT_CELLS);
      end else begin
        s1_s.cy       = s1_r.cy + CY_W'(1);
      end
    end else begin
      s1_s.cy = s1_r.cy;
    end
  end

  // stage 1 registers and sync flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r     <= '0;
      synced_r <= 1'b0;
    end else begin
      s1_r     <= s1_s;
      synced_r <= synced_r | frame_start_s;
    end
  end

  // stage 2: gated output fields and cursor compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.en           <= 1'b0;
      bus.char_index   <= '0;
      bus.char_pixel_x <= '0;
      bus.char_pixel_y <= '0;
      bus.cursor_hit   <= 1'b0;
    end else begin
      bus.en           <= s1_r.win;
      bus.char_index   <= s1_r.win ? idx_s : '0;
      bus.char_pixel_x <= s1_r.win ? s1_r.cx : '0;
      bus.char_pixel_y <= s1_r.win ? s1_r.cy : '0;
      bus.cursor_hit   <= s1_r.win & bus.cursor_en & phase_visible_s &
                          (idx_s == bus.cursor_index);
    end
  end

  frame_blink_counter #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick_s),
    .phase_visible(phase_visible_s)
  );

endmodule
